// File: rtl/fasta_base_feeder_if.sv
// Byte-stream input and encoded-base output bundle for fasta_base_feeder.
// slave is the feeder's own view; master is the view of whatever drives and observes it.
interface fasta_base_feeder_if #(
  parameter int LEN_WIDTH    = 12,
  parameter int SEQ_ID_WIDTH = 8
);
  logic [7:0]              char_in;
  logic                    char_vld;
  logic                    char_last;
  logic                    char_rdy;
  logic [1:0]              data_out;
  logic                    en_out;
  logic                    seq_first;
  logic                    seq_done;
  logic [LEN_WIDTH-1:0]    seq_len;
  logic [SEQ_ID_WIDTH-1:0] seq_id;
  logic                    err;
  logic                    err_clr;

  modport master (
    output char_in, char_vld, char_last, err_clr,
    input  char_rdy, data_out, en_out, seq_first, seq_done, seq_len, seq_id, err
  );

  modport slave (
    input  char_in, char_vld, char_last, err_clr,
    output char_rdy, data_out, en_out, seq_first, seq_done, seq_len, seq_id, err
  );
endinterface

// File: rtl/fasta_base_feeder.sv
// FASTA byte-stream parser feeding 2-bit encoded bases to the systolic scoring array.
// Optional macro FEEDER_N_SUBST_EN: encode N/n as A instead of flagging it as an error.
module fasta_base_feeder #(
  parameter int GAP_CYCLES   = 1,
  parameter int LEN_WIDTH    = 12,
  parameter int SEQ_ID_WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  fasta_base_feeder_if.slave bus
);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0]        GAP_LOAD = GW'(GAP_CYCLES - 1);
  localparam logic [LEN_WIDTH-1:0] LEN_MAX  = '1;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_GT = 8'h3E;

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_SEQ, S_GAP} state_e;

  state_e                  state_q, resume_q;
  logic [GW-1:0]           gap_q;
  logic [LEN_WIDTH-1:0]    cnt_q, len_q;
  logic [SEQ_ID_WIDTH-1:0] id_q;
  logic [1:0]              data_q;
  logic                    en_q, first_q, done_q, err_q;

  logic                 accept, is_base, is_ws, is_gt, seq_end, nonempty, len_sat;
  logic [1:0]           base_code;
  logic [LEN_WIDTH-1:0] cnt_d, len_d;

  assign bus.char_rdy = ~rst & (state_q != S_GAP);
  assign accept       = bus.char_vld & bus.char_rdy;

  always_comb begin
    is_base   = 1'b1;
    base_code = 2'b00;
    case (bus.char_in)
      "A", "a": base_code = 2'b10;
      "G", "g": base_code = 2'b11;
      "T", "t": base_code = 2'b00;
      "C", "c": base_code = 2'b01;
`ifdef FEEDER_N_SUBST_EN
      "N", "n": base_code = 2'b10;
`endif
      default:  is_base   = 1'b0;
    endcase
  end

  assign is_ws    = (bus.char_in == CH_LF) || (bus.char_in == CH_CR) || (bus.char_in == CH_SP);
  assign is_gt    = (bus.char_in == CH_GT);
  assign len_sat  = (cnt_q == LEN_MAX);
  assign cnt_d    = len_sat ? cnt_q : cnt_q + 1'b1;
  assign len_d    = is_base ? cnt_d : cnt_q;
  assign nonempty = is_base || (cnt_q != '0);
  // char_last terminates a sequence on any byte, not only on bases
  assign seq_end  = accept && (state_q == S_SEQ) && (bus.char_last || is_gt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      resume_q <= S_IDLE;
      gap_q    <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      id_q     <= '0;
      data_q   <= 2'b00;
      en_q     <= 1'b0;
      first_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      en_q    <= 1'b0;
      first_q <= 1'b0;
      done_q  <= 1'b0;
      if (bus.err_clr) err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept && is_gt && !bus.char_last) state_q <= S_HEADER;
        end
        S_HEADER: begin
          if (accept) begin
            if (bus.char_last) begin
              state_q <= S_IDLE;
            end else if (bus.char_in == CH_LF) begin
              state_q <= S_SEQ;
              cnt_q   <= '0;
            end
          end
        end
        S_SEQ: begin
          if (accept && is_base) begin
            en_q    <= 1'b1;
            data_q  <= base_code;
            first_q <= (cnt_q == '0);
            cnt_q   <= cnt_d;
            if (len_sat) err_q <= 1'b1;
          end
          if (accept && !is_base && !is_ws && !is_gt) err_q <= 1'b1;
          if (seq_end) begin
            resume_q <= bus.char_last ? S_IDLE : S_HEADER;
            if (nonempty) begin
              state_q <= S_GAP;
              done_q  <= 1'b1;
              len_q   <= len_d;
              gap_q   <= GAP_LOAD;
            end else begin
              state_q <= bus.char_last ? S_IDLE : S_HEADER;
            end
          end
        end
        S_GAP: begin
          if (gap_q == '0) begin
            state_q <= resume_q;
            id_q    <= id_q + 1'b1;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.data_out  = data_q;
  assign bus.en_out    = en_q;
  assign bus.seq_first = first_q;
  assign bus.seq_done  = done_q;
  assign bus.seq_len   = len_q;
  assign bus.seq_id    = id_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_fasta_base_feeder.sv
// Bench for fasta_base_feeder: two instances (LEN_WIDTH 12 and 3) share one FASTA stream,
// whose expected bases, sequence records and error flags are built alongside the stream.
module tb_fasta_base_feeder;
  localparam int GAP = 1;
  localparam logic [7:0] LF = 8'h0A;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] char_in = 8'h00;
  logic char_vld = 1'b0, char_last = 1'b0, err_clr = 1'b0;
  logic cur_base = 1'b0;
  logic acc_base_q = 1'b0;
  bit   mon_on = 1'b0;

  fasta_base_feeder_if #(.LEN_WIDTH(12), .SEQ_ID_WIDTH(8)) bus0 ();
  fasta_base_feeder_if #(.LEN_WIDTH(3),  .SEQ_ID_WIDTH(8)) bus1 ();

  assign bus0.char_in = char_in;  assign bus1.char_in = char_in;
  assign bus0.char_vld = char_vld; assign bus1.char_vld = char_vld;
  assign bus0.char_last = char_last; assign bus1.char_last = char_last;
  assign bus0.err_clr = err_clr;  assign bus1.err_clr = err_clr;

  fasta_base_feeder #(.GAP_CYCLES(GAP), .LEN_WIDTH(12), .SEQ_ID_WIDTH(8)) u0 (.clk(clk), .rst(rst), .bus(bus0));
  fasta_base_feeder #(.GAP_CYCLES(GAP), .LEN_WIDTH(3),  .SEQ_ID_WIDTH(8)) u1 (.clk(clk), .rst(rst), .bus(bus1));

  initial forever #5 clk = ~clk;

  typedef struct {byte c; bit last; bit base; bit clr;} ent_t;
  ent_t sq[$];

  logic [1:0] q_code[$];
  bit         q_first[$];
  int         q_len[$];
  int         q_id[$];
  int  bi[2], di[2], gl[2];
  bit  exp_err[2];
  int  gen_id = 0, gen_cnt = 0;
  bit  gen_in_seq = 0, clr_on_x = 0;
  int  n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // ---------------- reference model: built while the stream is generated ----------------
  function automatic void push_b(byte c, bit base, bit clr);
    ent_t e;
    e.c = c; e.last = 1'b0; e.base = base; e.clr = clr;
    sq.push_back(e);
  endfunction

  function automatic void seq_char(byte c);
    logic [1:0] code = 2'b00;
    bit base = 1'b1;
    case (c)
      "A", "a": code = 2'b10;
      "G", "g": code = 2'b11;
      "T", "t": code = 2'b00;
      "C", "c": code = 2'b01;
`ifdef FEEDER_N_SUBST_EN
      "N", "n": code = 2'b10;
`endif
      default:  base = 1'b0;
    endcase
    if (base) begin
      q_code.push_back(code);
      q_first.push_back(gen_cnt == 0);
      gen_cnt++;
      if (gen_cnt > 7)    exp_err[1] = 1'b1;
      if (gen_cnt > 4095) exp_err[0] = 1'b1;
    end else if (!(c == LF || c == 8'h0D || c == " ")) begin
      exp_err[0] = 1'b1;
      exp_err[1] = 1'b1;
    end
    push_b(c, base, clr_on_x && (c == "X"));
  endfunction

  function automatic void end_record();
    if (gen_in_seq && gen_cnt > 0) begin
      q_len.push_back(gen_cnt);
      q_id.push_back(gen_id);
      gen_id = (gen_id + 1) % 256;
    end
    gen_in_seq = 1'b0;
    gen_cnt = 0;
  endfunction

  function automatic void rec(string hdr, string body);
    end_record();
    push_b(">", 0, 0);
    for (int i = 0; i < hdr.len(); i++) push_b(hdr[i], 0, 0);
    push_b(LF, 0, 0);
    gen_in_seq = 1'b1;
    gen_cnt = 0;
    for (int i = 0; i < body.len(); i++) seq_char(body[i]);
  endfunction

  function automatic void finish_stream();
    sq[sq.size()-1].last = 1'b1;
    end_record();
  endfunction

  function automatic void clear_model();
    q_code.delete(); q_first.delete(); q_len.delete(); q_id.delete();
    for (int k = 0; k < 2; k++) begin bi[k] = 0; di[k] = 0; gl[k] = 0; exp_err[k] = 1'b0; end
    gen_id = 0; gen_cnt = 0; gen_in_seq = 1'b0;
  endfunction

  function automatic void rand_stream();
    string hal = "ab>AC 1";
    string bal = "ACGTACGTacgtNn \r\nX";
    int nrec = $urandom_range(1, 4);
    if ($urandom_range(0, 1) == 1) begin
      push_b("x", 0, 0); push_b("A", 0, 0); push_b(LF, 0, 0);
    end
    for (int r = 0; r < nrec; r++) begin
      end_record();
      push_b(">", 0, 0);
      for (int i = 0; i < $urandom_range(0, 4); i++) push_b(hal[$urandom_range(0, hal.len()-1)], 0, 0);
      push_b(LF, 0, 0);
      gen_in_seq = 1'b1;
      gen_cnt = 0;
      for (int i = 0; i < $urandom_range(0, 12); i++) seq_char(bal[$urandom_range(0, bal.len()-1)]);
    end
    finish_stream();
  endfunction

  // ---------------- output monitor ----------------
  always @(posedge clk) acc_base_q <= char_vld & bus0.char_rdy & cur_base;

  task automatic mon(input int k, input logic en, input logic [1:0] d, input logic fst,
                     input logic dn, input logic [31:0] len, input logic [31:0] id,
                     input logic rdy, input int maxlen);
    chk($sformatf("en_timing%0d", k), en, acc_base_q);
    if (en) begin
      chk($sformatf("base_expected%0d", k), bi[k] < q_code.size(), 1);
      if (bi[k] < q_code.size()) begin
        chk($sformatf("data_out%0d", k), d, q_code[bi[k]]);
        chk($sformatf("seq_first%0d", k), fst, q_first[bi[k]]);
      end
      bi[k]++;
    end else begin
      chk($sformatf("seq_first_idle%0d", k), fst, 0);
    end
    if (dn) begin
      chk($sformatf("done_expected%0d", k), di[k] < q_len.size(), 1);
      if (di[k] < q_len.size()) begin
        chk($sformatf("seq_len%0d", k), len, (q_len[di[k]] > maxlen) ? maxlen : q_len[di[k]]);
        chk($sformatf("seq_id%0d", k), id, q_id[di[k]]);
      end
      di[k]++;
      gl[k] = GAP;
    end
    if (gl[k] > 0) begin
      chk($sformatf("rdy_gap%0d", k), rdy, 0);
      gl[k]--;
    end else begin
      chk($sformatf("rdy_open%0d", k), rdy, 1);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      mon(0, bus0.en_out, bus0.data_out, bus0.seq_first, bus0.seq_done,
          32'(bus0.seq_len), 32'(bus0.seq_id), bus0.char_rdy, 4095);
      mon(1, bus1.en_out, bus1.data_out, bus1.seq_first, bus1.seq_done,
          32'(bus1.seq_len), 32'(bus1.seq_id), bus1.char_rdy, 7);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic send_all();
    for (int i = 0; i < sq.size(); i++) begin
      int n = 0;
      logic acc = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        char_vld = 1'b0; cur_base = 1'b0; err_clr = 1'b0;
        @(posedge clk); #1;
      end
      char_in = sq[i].c; char_last = sq[i].last; cur_base = sq[i].base;
      err_clr = sq[i].clr; char_vld = 1'b1;
      while (!acc) begin
        @(negedge clk);
        acc = bus0.char_rdy;
        @(posedge clk); #1;
        n++;
        if (n > 50) begin
          n_chk++;
          $display("FAIL accept_timeout observed=no_accept expected=accept_within_50");
          $fatal(1, "byte never accepted");
        end
      end
    end
    char_vld = 1'b0; char_last = 1'b0; cur_base = 1'b0; err_clr = 1'b0;
    sq.delete();
  endtask

  task automatic drain_and_check(input string tag);
    repeat (GAP + 4) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_bases%0d", tag, k), bi[k], q_code.size());
      chk($sformatf("%s_dones%0d", tag, k), di[k], q_len.size());
    end
    chk({tag, "_err0"}, bus0.err, exp_err[0]);
    chk({tag, "_err1"}, bus1.err, exp_err[1]);
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("err_clr0", bus0.err, 0);
    chk("err_clr1", bus1.err, 0);
    exp_err[0] = 1'b0;
    exp_err[1] = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rdy0"},  bus0.char_rdy, 0);  chk({tag, "_rdy1"},  bus1.char_rdy, 0);
    chk({tag, "_en0"},   bus0.en_out, 0);    chk({tag, "_en1"},   bus1.en_out, 0);
    chk({tag, "_data0"}, bus0.data_out, 0);  chk({tag, "_data1"}, bus1.data_out, 0);
    chk({tag, "_first0"}, bus0.seq_first, 0); chk({tag, "_first1"}, bus1.seq_first, 0);
    chk({tag, "_done0"}, bus0.seq_done, 0);  chk({tag, "_done1"}, bus1.seq_done, 0);
    chk({tag, "_len0"},  32'(bus0.seq_len), 0); chk({tag, "_len1"}, 32'(bus1.seq_len), 0);
    chk({tag, "_id0"},   32'(bus0.seq_id), 0);  chk({tag, "_id1"},  32'(bus1.seq_id), 0);
    chk({tag, "_err0"},  bus0.err, 0);       chk({tag, "_err1"},  bus1.err, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    clear_model();
    #3;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_on = 1'b1;

    rec("s0", "ACGT"); finish_stream(); send_all(); drain_and_check("t1");

    rec("a", "AC\nGT\n"); rec("b", "TT"); finish_stream(); send_all(); drain_and_check("t2");

    rec("e", ""); rec("f", "G"); finish_stream(); send_all(); drain_and_check("t3");

    clr_on_x = 1'b1;
    rec("x", "AXNC"); finish_stream(); send_all(); drain_and_check("t4");
    clr_on_x = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("err_sticky0", bus0.err, 1);
    chk("err_sticky1", bus1.err, 1);
    clear_err();

    rec("l", "ACGTACGTA"); finish_stream(); send_all(); drain_and_check("t6");
    clear_err();

    // reset in the middle of a sequence, right after its third base is accepted
    rec("r", "AC"); send_all();
    char_in = "G"; char_last = 1'b0; cur_base = 1'b1; char_vld = 1'b1;
    @(negedge clk);
    mon_on = 1'b0;
    @(posedge clk); #1;
    chk("third_base_en", bus0.en_out, 1);
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    char_vld = 1'b0; cur_base = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_model();
    mon_on = 1'b1;
    rec("s", "TT"); finish_stream(); send_all(); drain_and_check("t5");

    for (int r = 0; r < 12; r++) begin
      rand_stream();
      send_all();
      drain_and_check($sformatf("rand%0d", r));
      clear_err();
    end

    mon_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
